// File: rtl/systolic_array_os_if.sv
// rtl/systolic_array_os_if.sv - job control, operand stream and result stream bundle for systolic_array_os
interface systolic_array_os_if #(
    parameter int N    = 4,
    parameter int DW   = 8,
    parameter int KW   = 8,
    parameter int ACCW = 2*DW+KW
);
    localparam int RW = $clog2(N);

    logic              start;
    logic [KW-1:0]     k_len;
    logic              in_valid;
    logic              in_ready;
    logic [N*DW-1:0]   a_in;
    logic [N*DW-1:0]   b_in;
    logic              out_valid;
    logic              out_ready;
    logic [RW-1:0]     out_row_idx;
    logic [N*ACCW-1:0] out_data;
    logic              busy;
    logic              done;

    modport master (
        output start, k_len, in_valid, a_in, b_in, out_ready,
        input  in_ready, out_valid, out_row_idx, out_data, busy, done
    );

    modport slave (
        input  start, k_len, in_valid, a_in, b_in, out_ready,
        output in_ready, out_valid, out_row_idx, out_data, busy, done
    );
endinterface

// File: rtl/systolic_array_os.sv
// rtl/systolic_array_os.sv - N x N output-stationary systolic matrix multiply with skewed operand entry
module systolic_array_os #(
    parameter int N    = 4,
    parameter int DW   = 8,
    parameter int KW   = 8,
    parameter int ACCW = 2*DW+KW
) (
    input  logic               clk,
    input  logic               rst_n,
    systolic_array_os_if.slave bus
);
    localparam int RW  = $clog2(N);
    localparam int DCW = $clog2(2*N);

    typedef enum logic [1:0] {S_IDLE, S_LOAD, S_DRAIN, S_READ} state_t;

    state_t         state_q, state_d;
    logic [KW-1:0]  k_q, k_d;
    logic [KW-1:0]  cnt_q, cnt_d;
    logic [DCW-1:0] drain_q, drain_d;
    logic [RW-1:0]  row_q, row_d;
    logic           done_q, done_d;
    logic           clear_acc;
    logic           accept;

    logic signed [DW-1:0]   a_sk_q  [N][N-1];
    logic                   a_skv_q [N][N-1];
    logic signed [DW-1:0]   b_sk_q  [N][N-1];
    logic                   b_skv_q [N][N-1];
    logic signed [DW-1:0]   a_h_q   [N][N-1];
    logic                   a_hv_q  [N][N-1];
    logic signed [DW-1:0]   b_h_q   [N-1][N];
    logic                   b_hv_q  [N-1][N];
    logic signed [DW-1:0]   a_op    [N][N];
    logic                   a_v     [N][N];
    logic signed [DW-1:0]   b_op    [N][N];
    logic                   b_v     [N][N];
    logic signed [ACCW-1:0] acc_q   [N][N];

    function automatic logic signed [ACCW-1:0] mac(input logic signed [ACCW-1:0] acc,
                                                   input logic signed [DW-1:0]   a,
                                                   input logic signed [DW-1:0]   b);
        logic signed [2*DW-1:0] p;
        p = (2*DW)'(a) * (2*DW)'(b);
        return acc + {{(ACCW-2*DW){p[2*DW-1]}}, p};
    endfunction

    assign accept = (state_q == S_LOAD) && bus.in_valid;

    // PE(0,0) sees the accepted vector directly; every other PE is fed from a skew stage or neighbour register
    always_comb begin
        for (int i = 0; i < N; i++) begin
            for (int j = 0; j < N; j++) begin
                if (j == 0) begin
                    a_op[i][j] = (i == 0) ? bus.a_in[0 +: DW] : a_sk_q[i][(i > 0) ? i - 1 : 0];
                    a_v[i][j]  = (i == 0) ? accept : a_skv_q[i][(i > 0) ? i - 1 : 0];
                end else begin
                    a_op[i][j] = a_h_q[i][(j > 0) ? j - 1 : 0];
                    a_v[i][j]  = a_hv_q[i][(j > 0) ? j - 1 : 0];
                end
                if (i == 0) begin
                    b_op[i][j] = (j == 0) ? bus.b_in[0 +: DW] : b_sk_q[j][(j > 0) ? j - 1 : 0];
                    b_v[i][j]  = (j == 0) ? accept : b_skv_q[j][(j > 0) ? j - 1 : 0];
                end else begin
                    b_op[i][j] = b_h_q[(i > 0) ? i - 1 : 0][j];
                    b_v[i][j]  = b_hv_q[(i > 0) ? i - 1 : 0][j];
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < N; i++) begin
                for (int d = 0; d < N-1; d++) begin
                    a_sk_q[i][d]  <= '0;
                    a_skv_q[i][d] <= 1'b0;
                    b_sk_q[i][d]  <= '0;
                    b_skv_q[i][d] <= 1'b0;
                    a_h_q[i][d]   <= '0;
                    a_hv_q[i][d]  <= 1'b0;
                end
            end
            for (int i = 0; i < N-1; i++) begin
                for (int j = 0; j < N; j++) begin
                    b_h_q[i][j]  <= '0;
                    b_hv_q[i][j] <= 1'b0;
                end
            end
        end else begin
            for (int i = 0; i < N; i++) begin
                a_sk_q[i][0]  <= bus.a_in[i*DW +: DW];
                a_skv_q[i][0] <= accept;
                b_sk_q[i][0]  <= bus.b_in[i*DW +: DW];
                b_skv_q[i][0] <= accept;
                for (int d = 1; d < N-1; d++) begin
                    a_sk_q[i][d]  <= a_sk_q[i][d-1];
                    a_skv_q[i][d] <= a_skv_q[i][d-1];
                    b_sk_q[i][d]  <= b_sk_q[i][d-1];
                    b_skv_q[i][d] <= b_skv_q[i][d-1];
                end
                for (int j = 0; j < N-1; j++) begin
                    a_h_q[i][j]  <= a_op[i][j];
                    a_hv_q[i][j] <= a_v[i][j];
                end
            end
            for (int i = 0; i < N-1; i++) begin
                for (int j = 0; j < N; j++) begin
                    b_h_q[i][j]  <= b_op[i][j];
                    b_hv_q[i][j] <= b_v[i][j];
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n || clear_acc) begin
            for (int i = 0; i < N; i++)
                for (int j = 0; j < N; j++)
                    acc_q[i][j] <= '0;
        end else begin
            for (int i = 0; i < N; i++)
                for (int j = 0; j < N; j++)
                    if (a_v[i][j] && b_v[i][j])
                        acc_q[i][j] <= mac(acc_q[i][j], a_op[i][j], b_op[i][j]);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            k_q     <= '0;
            cnt_q   <= '0;
            drain_q <= '0;
            row_q   <= '0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            k_q     <= k_d;
            cnt_q   <= cnt_d;
            drain_q <= drain_d;
            row_q   <= row_d;
            done_q  <= done_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        k_d       = k_q;
        cnt_d     = cnt_q;
        drain_d   = drain_q;
        row_d     = row_q;
        done_d    = 1'b0;
        clear_acc = 1'b0;
        case (state_q)
            S_IDLE: begin
                // the done cycle still belongs to the finished job, so a start there is dropped
                if (bus.start && !done_q) begin
                    clear_acc = 1'b1;
                    k_d       = bus.k_len;
                    cnt_d     = '0;
                    row_d     = '0;
                    state_d   = (bus.k_len != '0) ? S_LOAD : S_READ;
                end
            end
            S_LOAD: begin
                if (accept) begin
                    cnt_d = cnt_q + 1'b1;
                    if (cnt_q == k_q - 1'b1) begin
                        drain_d = '0;
                        state_d = S_DRAIN;
                    end
                end
            end
            S_DRAIN: begin
                if (drain_q == DCW'(2*N-2))
                    state_d = S_READ;
                else
                    drain_d = drain_q + 1'b1;
            end
            S_READ: begin
                if (bus.out_ready) begin
                    if (row_q == RW'(N-1)) begin
                        row_d   = '0;
                        done_d  = 1'b1;
                        state_d = S_IDLE;
                    end else begin
                        row_d = row_q + 1'b1;
                    end
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    assign bus.in_ready    = (state_q == S_LOAD);
    assign bus.out_valid   = (state_q == S_READ);
    assign bus.busy        = (state_q != S_IDLE);
    assign bus.done        = done_q;
    assign bus.out_row_idx = row_q;

    always_comb begin
        bus.out_data = '0;
        for (int j = 0; j < N; j++)
            bus.out_data[j*ACCW +: ACCW] = acc_q[row_q][j];
    end
endmodule

// File: tb/tb_systolic_array_os.sv
// tb/tb_systolic_array_os.sv - self-checking bench for systolic_array_os using N=2 and N=4 instances
module tb_systolic_array_os;
    localparam int DW   = 8;
    localparam int KW   = 8;
    localparam int ACCW = 2*DW+KW;
    localparam int NMAX = 4;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    logic                 sel;
    logic                 start_s;
    logic [KW-1:0]        k_s;
    logic                 in_valid_s;
    logic [NMAX*DW-1:0]   a_s;
    logic [NMAX*DW-1:0]   b_s;
    logic                 out_ready_s;

    systolic_array_os_if #(.N(2), .DW(DW), .KW(KW), .ACCW(ACCW)) if2 ();
    systolic_array_os_if #(.N(4), .DW(DW), .KW(KW), .ACCW(ACCW)) if4 ();

    systolic_array_os #(.N(2), .DW(DW), .KW(KW), .ACCW(ACCW)) u_dut2 (.clk(clk), .rst_n(rst_n), .bus(if2.slave));
    systolic_array_os #(.N(4), .DW(DW), .KW(KW), .ACCW(ACCW)) u_dut4 (.clk(clk), .rst_n(rst_n), .bus(if4.slave));

    assign if2.start     = start_s & ~sel;
    assign if2.k_len     = k_s;
    assign if2.in_valid  = in_valid_s & ~sel;
    assign if2.a_in      = a_s[2*DW-1:0];
    assign if2.b_in      = b_s[2*DW-1:0];
    assign if2.out_ready = out_ready_s & ~sel;
    assign if4.start     = start_s & sel;
    assign if4.k_len     = k_s;
    assign if4.in_valid  = in_valid_s & sel;
    assign if4.a_in      = a_s;
    assign if4.b_in      = b_s;
    assign if4.out_ready = out_ready_s & sel;

    logic                   m_in_ready, m_out_valid, m_busy, m_done;
    logic [1:0]             m_row;
    logic [NMAX*ACCW-1:0]   m_data;
    assign m_in_ready  = sel ? if4.in_ready  : if2.in_ready;
    assign m_out_valid = sel ? if4.out_valid : if2.out_valid;
    assign m_busy      = sel ? if4.busy      : if2.busy;
    assign m_done      = sel ? if4.done      : if2.done;
    assign m_row       = sel ? if4.out_row_idx : {1'b0, if2.out_row_idx};
    assign m_data      = sel ? if4.out_data  : {{(2*ACCW){1'b0}}, if2.out_data};

    typedef struct { int idx; logic [NMAX*ACCW-1:0] data; } row_t;
    typedef struct { bit sel; int k; int av; int bv; int gap; int exp_lane; } vec_t;

    row_t sb_q[$];
    int   A_m [NMAX][256];
    int   B_m [256][NMAX];
    int   tests = 0;
    int   fails = 0;

    task automatic check(input string name, input logic [NMAX*ACCW-1:0] act, input logic [NMAX*ACCW-1:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic void push_model(input int n, input int k);
        row_t r;
        for (int i = 0; i < n; i++) begin
            r.idx  = i;
            r.data = '0;
            for (int j = 0; j < n; j++) begin
                int sum = 0;
                for (int v = 0; v < k; v++) sum += A_m[i][v] * B_m[v][j];
                r.data[j*ACCW +: ACCW] = ACCW'(sum);
            end
            sb_q.push_back(r);
        end
    endfunction

    function automatic void push_const(input int n, input int val);
        row_t r;
        for (int i = 0; i < n; i++) begin
            r.idx  = i;
            r.data = '0;
            for (int j = 0; j < n; j++) r.data[j*ACCW +: ACCW] = ACCW'(val);
            sb_q.push_back(r);
        end
    endfunction

    task automatic drive_vec(input int n, input int v);
        a_s = '0;
        b_s = '0;
        for (int i = 0; i < n; i++) begin
            a_s[i*DW +: DW] = DW'(A_m[i][v]);
            b_s[i*DW +: DW] = DW'(B_m[v][i]);
        end
    endtask

    // Entered and left on a falling edge; inputs change and outputs are sampled only there.
    task automatic run_job(input int n, input int k, input int gap, input bit drain_valid,
                           input int hold, input bit start_mid, input bit start_at_done);
        int tmo, lat, ir_seen;
        row_t e;
        start_s = 1'b1;
        k_s     = KW'(k);
        @(negedge clk);
        start_s = 1'b0;
        check("busy_after_start", m_busy, 1);
        for (int v = 0; v < k; v++) begin
            drive_vec(n, v);
            in_valid_s = 1'b1;
            if (start_mid && v == 1) begin
                start_s = 1'b1;
                k_s     = 8'd1;
            end
            tmo = 0;
            while (!m_in_ready && tmo < 20) begin
                @(negedge clk);
                tmo++;
            end
            if (tmo >= 20) check("in_ready_timeout", 0, 1);
            @(negedge clk);
            start_s    = 1'b0;
            in_valid_s = 1'b0;
            if (v < k - 1) repeat (gap) @(negedge clk);
        end
        in_valid_s = drain_valid;
        if (drain_valid) begin
            a_s = '1;
            b_s = '1;
        end
        lat = 0;
        ir_seen = 0;
        while (!m_out_valid && lat < 600) begin
            if (m_in_ready) ir_seen++;
            @(negedge clk);
            lat++;
        end
        in_valid_s = 1'b0;
        check("first_out_latency", lat, (k == 0) ? 0 : 2*n-1);
        check("in_ready_outside_load", ir_seen, 0);
        for (int h = 0; h < hold; h++) begin
            check("hold_valid", m_out_valid, 1);
            check("hold_row_idx", m_row, 0);
            check("hold_no_done", m_done, 0);
            if (sb_q.size() > 0) check("hold_data", m_data, sb_q[0].data);
            else check("hold_sb_empty", 0, 1);
            @(negedge clk);
        end
        out_ready_s = 1'b1;
        for (int r = 0; r < n; r++) begin
            check("row_valid", m_out_valid, 1);
            if (sb_q.size() > 0) begin
                e = sb_q.pop_front();
                check("row_idx", m_row, e.idx);
                check("row_data", m_data, e.data);
            end else begin
                check("row_sb_empty", 0, 1);
            end
            @(negedge clk);
        end
        out_ready_s = 1'b0;
        check("done_pulse", m_done, 1);
        check("valid_low_at_done", m_out_valid, 0);
        check("busy_low_at_done", m_busy, 0);
        if (start_at_done) begin
            start_s = 1'b1;
            k_s     = 8'd1;
        end
        @(negedge clk);
        start_s = 1'b0;
        check("done_single_cycle", m_done, 0);
        check("idle_after_done", m_busy, 0);
    endtask

    task automatic load_identity_case();
        A_m[0][0] = 1; A_m[0][1] = 2;
        A_m[1][0] = 3; A_m[1][1] = 4;
        B_m[0][0] = 1; B_m[0][1] = 0;
        B_m[1][0] = 0; B_m[1][1] = 1;
    endtask

    task automatic load_random(input int n, input int k);
        for (int v = 0; v < k; v++)
            for (int i = 0; i < n; i++) begin
                A_m[i][v] = int'($urandom_range(0, 255)) - 128;
                B_m[v][i] = int'($urandom_range(0, 255)) - 128;
            end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        vec_t tbl[5];
        tbl[0] = '{1'b1, 255, -128, -128, 0,  4177920};
        tbl[1] = '{1'b1, 255,  127, -128, 0, -4145280};
        tbl[2] = '{1'b0,   3,    5,   -7, 1,     -105};
        tbl[3] = '{1'b1,   1,   -1,   -1, 2,        1};
        tbl[4] = '{1'b0, 255,  127,  127, 0,  4112895};

        sel = 1'b0; start_s = 1'b0; k_s = '0; in_valid_s = 1'b0;
        a_s = '0; b_s = '0; out_ready_s = 1'b0;
        #1;
        for (int s = 0; s < 2; s++) begin
            sel = s[0];
            #1;
            check("rst_in_ready", m_in_ready, 0);
            check("rst_out_valid", m_out_valid, 0);
            check("rst_busy", m_busy, 0);
            check("rst_done", m_done, 0);
            check("rst_row_idx", m_row, 0);
            check("rst_out_data", m_data, 0);
        end
        sel = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        load_identity_case();
        push_model(2, 2);
        run_job(2, 2, 0, 1'b0, 0, 1'b0, 1'b1);

        load_identity_case();
        push_model(2, 2);
        run_job(2, 2, 3, 1'b1, 0, 1'b0, 1'b0);

        sel = 1'b1;
        load_random(4, 5);
        push_model(4, 5);
        run_job(4, 5, 0, 1'b0, 5, 1'b0, 1'b0);

        for (int t = 0; t < 5; t++) begin
            sel = tbl[t].sel;
            for (int v = 0; v < tbl[t].k; v++)
                for (int i = 0; i < NMAX; i++) begin
                    A_m[i][v] = tbl[t].av;
                    B_m[v][i] = tbl[t].bv;
                end
            push_const(sel ? 4 : 2, tbl[t].exp_lane);
            run_job(sel ? 4 : 2, tbl[t].k, tbl[t].gap, 1'b0, 0, 1'b0, 1'b0);
        end

        sel = 1'b1;
        push_const(4, 0);
        run_job(4, 0, 0, 1'b0, 0, 1'b0, 1'b0);

        load_random(4, 6);
        push_model(4, 6);
        run_job(4, 6, 1, 1'b0, 0, 1'b1, 1'b0);

        sel = 1'b0;
        load_random(2, 3);
        start_s = 1'b1;
        k_s     = 8'd3;
        @(negedge clk);
        start_s = 1'b0;
        drive_vec(2, 0);
        in_valid_s = 1'b1;
        @(negedge clk);
        drive_vec(2, 1);
        #2;
        rst_n = 1'b0;
        #1;
        check("abort_in_ready", m_in_ready, 0);
        check("abort_busy", m_busy, 0);
        check("abort_out_valid", m_out_valid, 0);
        check("abort_done", m_done, 0);
        check("abort_row_idx", m_row, 0);
        check("abort_out_data", m_data, 0);
        @(negedge clk);
        rst_n      = 1'b1;
        in_valid_s = 1'b0;
        @(negedge clk);
        check("abort_no_done", m_done, 0);
        check("abort_idle", m_busy, 0);
        A_m[0][0] = -5; A_m[0][1] = 7;
        A_m[1][0] = 9;  A_m[1][1] = -2;
        B_m[0][0] = 3;  B_m[0][1] = -4;
        B_m[1][0] = 6;  B_m[1][1] = 11;
        push_model(2, 2);
        run_job(2, 2, 0, 1'b0, 0, 1'b0, 1'b0);

        check("scoreboard_drained", sb_q.size(), 0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
